// File: rtl/jkff_counter.sv
// WIDTH-bit bank of JK flip-flops on D storage: parallel load, direct JK control, up/down counter.
// q updates one clk edge after inputs are sampled; tc is combinational; no backpressure.
module jkff_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j_sel;
  logic [WIDTH-1:0] k_sel;
  logic [WIDTH-1:0] d;
  logic             carry;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    t     = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & (up ? q[i] : ~q[i]);
    end
  end

  always_comb begin
    j_sel = '0;
    k_sel = '0;
    if (load) begin
      j_sel = load_val;
      k_sel = ~load_val;
    end else if (mode) begin
      j_sel = j;
      k_sel = k;
    end else if (en) begin
      j_sel = t;
      k_sel = t;
    end
  end

  assign d = (j_sel & ~q) | (~k_sel & q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign qbar = ~q;

  // Gated by rst_n so the all-zero reset state never reads as a down-count wrap.
  assign tc = rst_n & ~load & ~mode & en & (up ? (&q) : ~(|q));

endmodule
